// File: rtl/temp_to_adc_encoder_pkg.sv
// Shared constants and types for the Celsius-to-ADC-code encoder.
package temp_enc_pkg;

    localparam int MAG_W      = 15;
    localparam int DIV_SHIFT  = 6;
    localparam int DIVIDEND_W = 38;
    localparam logic [MAG_W-1:0] SAT_MAG = 15'h7FFF;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_e;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } adc_code_t;

endpackage

// File: rtl/temp_to_adc_encoder_if.sv
// Request/response bus of the encoder: setpoint in, signed-magnitude ADC code out.
interface temp_to_adc_encoder_if;
    import temp_enc_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] tc_base;
    logic [7:0]  tc_ref;
    logic [31:0] tempc;
    logic        rsp_valid;
    logic        rsp_ready;
    adc_code_t   adc_data;
    logic        div_err;

    modport master (
        output req_valid, tc_base, tc_ref, tempc, rsp_ready,
        input  req_ready, rsp_valid, adc_data, div_err
    );

    modport slave (
        input  req_valid, tc_base, tc_ref, tempc, rsp_ready,
        output req_ready, rsp_valid, adc_data, div_err
    );

endinterface

// File: rtl/temp_to_adc_encoder_serial_divider_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module serial_divider_step (
    input  logic [15:0] rem_i,
    input  logic        bit_i,
    input  logic [15:0] div_i,
    output logic [15:0] rem_o,
    output logic        q_o
);
    logic [16:0] trial;

    always_comb begin
        trial = {rem_i, bit_i};
        q_o   = (trial >= {1'b0, div_i});
        rem_o = q_o ? 16'(trial - {1'b0, div_i}) : trial[15:0];
    end

endmodule

// File: rtl/temp_to_adc_encoder.sv
// Inverts temp = base +/- adc_mag*ref^2/64 with a 15-step serial divider.
// Optional macro TEMP_ENC_ROUND_NEAREST_EN selects round-to-nearest instead of floor.
module temp_to_adc_encoder
    import temp_enc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    temp_to_adc_encoder_if.slave   bus
);
    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [31:0]      tempc_q, base_q;
    logic [7:0]       ref_q;
    logic             sign_q, sat_q, err_q;
    logic [15:0]      div_q, rem_q;
    logic [MAG_W-1:0] lo_q, quo_q;
    adc_code_t        adc_q;
    logic             rsp_valid_q, req_ready_q, div_err_q;

    // Extra top bit keeps the rounding add from wrapping before the saturation test.
    logic [15:0]           ref2_d;
    logic                  sign_d;
    logic [31:0]           diff_d;
    logic [DIVIDEND_W:0]   dvd_d;
    logic                  sat_d;

    always_comb begin
        ref2_d = {8'b0, ref_q} * {8'b0, ref_q};
        sign_d = (tempc_q < base_q);
        diff_d = sign_d ? (base_q - tempc_q) : (tempc_q - base_q);
        dvd_d  = {1'b0, diff_d, {DIV_SHIFT{1'b0}}};
`ifdef TEMP_ENC_ROUND_NEAREST_EN
        dvd_d  = dvd_d + {24'b0, ref2_d[15:1]};
`else
        dvd_d  = dvd_d;
`endif
        sat_d  = (ref2_d == 16'd0) || (dvd_d >= {8'b0, ref2_d, 15'b0});
    end

    logic [15:0] rem_nx;
    logic        q_nx;

    serial_divider_step u_step (
        .rem_i (rem_q),
        .bit_i (lo_q[MAG_W-1]),
        .div_i (div_q),
        .rem_o (rem_nx),
        .q_o   (q_nx)
    );

    // Count 0..14 are division steps; count 15 registers the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tempc_q     <= '0;
            base_q      <= '0;
            ref_q       <= '0;
            sign_q      <= 1'b0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            div_q       <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            quo_q       <= '0;
            adc_q       <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            div_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        tempc_q     <= bus.tempc;
                        base_q      <= bus.tc_base;
                        ref_q       <= bus.tc_ref;
                        req_ready_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    sign_q  <= sign_d;
                    sat_q   <= sat_d;
                    err_q   <= (ref2_d == 16'd0);
                    div_q   <= ref2_d;
                    // Below saturation the top dividend bits are already smaller than ref2.
                    rem_q   <= dvd_d[30:15];
                    lo_q    <= dvd_d[14:0];
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= DIV;
                end
                DIV: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(MAG_W)) begin
                        adc_q       <= {sign_q, (sat_q ? SAT_MAG : quo_q)};
                        div_err_q   <= err_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q <= rem_nx;
                        lo_q  <= {lo_q[MAG_W-2:0], 1'b0};
                        quo_q <= {quo_q[MAG_W-2:0], q_nx};
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.adc_data  = adc_q;
    assign bus.div_err   = div_err_q;

endmodule

// File: tb/tb_temp_to_adc_encoder.sv
// Scoreboard bench for temp_to_adc_encoder: accepts push model results, a monitor pops on each response.
module tb_temp_to_adc_encoder;
    import temp_enc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    temp_to_adc_encoder_if bus();
    temp_to_adc_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adc;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          rdy_mode = 0;
    int          n_rsp = 0;
    logic [15:0] last_adc = '0;
    logic        last_err = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: plain arithmetic on the forward relation's inverse.
    function automatic exp_t model(input logic [31:0] b, input logic [7:0] r, input logic [31:0] t);
        exp_t e;
        logic s;
        longint unsigned diff, dvd, r2, mag;
        s    = (t < b);
        diff = s ? (longint'(b) - longint'(t)) : (longint'(t) - longint'(b));
        r2   = longint'(r) * longint'(r);
        dvd  = diff * 64;
`ifdef TEMP_ENC_ROUND_NEAREST_EN
        dvd  = dvd + r2 / 2;
`endif
        if (r2 == 0 || dvd >= r2 * 32768) mag = 32767;
        else mag = dvd / r2;
        e.adc = {s, mag[14:0]};
        e.err = (r2 == 0);
        e.acc = 0;
        return e;
    endfunction

    // Acceptance tracker: the expected response is queued at the accepting edge.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst_n && bus.req_valid && bus.req_ready) begin
            e = model(bus.tc_base, bus.tc_ref, bus.tempc);
            e.acc = cyc;
            sb.push_back(e);
        end
    end

    // Consumer readiness, driven just after the active edge.
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = (rdy_mode == 0) ? 1'b1 :
                            (rdy_mode == 2) ? 1'b0 : 1'($urandom % 2);
        end
    end

    // Monitor
    logic        prev_vld = 1'b0;
    logic [15:0] hold_adc = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (!prev_vld) begin
                    if (sb.size() == 0) check("unexpected_rsp", 1, 0);
                    else check("latency", cyc - sb[0].acc, 17);
                end else begin
                    check("hold_adc", bus.adc_data, hold_adc);
                end
                hold_adc = bus.adc_data;
                check("req_ready_busy", bus.req_ready, 0);
                if (bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("adc_data", bus.adc_data, e.adc);
                        check("div_err", bus.div_err, e.err);
                    end
                    last_adc = bus.adc_data;
                    last_err = bus.div_err;
                    n_rsp++;
                end
            end
            prev_vld = bus.rsp_valid;
        end
    end

    task automatic send(input logic [31:0] b, input logic [7:0] r, input logic [31:0] t);
        bit ok = 0;
        @(negedge clk);
        bus.tc_base = b; bus.tc_ref = r; bus.tempc = t; bus.req_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (bus.req_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.tc_base = $urandom; bus.tc_ref = 8'($urandom); bus.tempc = $urandom;
    endtask

    task automatic wait_rsp(input int n0);
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (n_rsp > n0) begin ok = 1; break; end
        end
        if (!ok) check("rsp_timeout", 0, 1);
    endtask

    task automatic run(input logic [31:0] b, input logic [7:0] r, input logic [31:0] t,
                       input logic [15:0] exp_adc, input logic exp_err);
        int n0 = n_rsp;
        send(b, r, t);
        wait_rsp(n0);
        check("dir_adc", last_adc, exp_adc);
        check("dir_err", last_err, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] first;
        logic [15:0] rnd_exp;
        bit ok;
        int n0;
        bus.req_valid = 1'b0;
        bus.tc_base = '0; bus.tc_ref = '0; bus.tempc = '0;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_adc", bus.adc_data, 16'h0000);
        check("rst_div_err", bus.div_err, 0);
        rst_n = 1'b1;

        run(25, 4, 35, 16'h0028, 1'b0);
        run(25, 4, 20, 16'h8014, 1'b0);
        run(0, 1, 600, 16'h7FFF, 1'b0);
        run(600, 1, 0, 16'hFFFF, 1'b0);
        run(10, 0, 12, 16'h7FFF, 1'b1);
        run(77, 9, 77, 16'h0000, 1'b0);
`ifdef TEMP_ENC_ROUND_NEAREST_EN
        rnd_exp = 16'h0024;
`else
        rnd_exp = 16'h0023;
`endif
        run(0, 3, 5, rnd_exp, 1'b0);

        // Stalled consumer
        rdy_mode = 2;
        n0 = n_rsp;
        send(25, 4, 35);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin ok = 1; break; end
        end
        if (!ok) check("stall_timeout", 0, 1);
        first = bus.adc_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_adc", bus.adc_data, first);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_valid", bus.rsp_valid, 1);
        end
        rdy_mode = 0;
        wait_rsp(n0);
        check("stall_result", last_adc, 16'h0028);

        // Reset mid-division
        send(25, 4, 35);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(25, 4, 20, 16'h8014, 1'b0);

        // Random traffic with random backpressure and req_valid held during busy
        rdy_mode = 1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            bus.req_valid = ($urandom % 3) != 0;
            bus.tc_ref    = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.tc_base   = $urandom_range(0, 2000);
            bus.tempc     = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 4000);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        rdy_mode = 0;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.rsp_valid) begin ok = 1; break; end
        end
        if (!ok) check("drain_timeout", 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
